keypad_scanner: RTL

- Upstream front end of the calculator datapath. Scans a 4x4 matrix keypad by driving one column at a time and reading the rows back.
- Synchronises and debounces key press and release, then decodes the key into a class (number / operation / equals / clear) with its value.
- Emits a single-cycle press pulse. The operand-entry counter, calculator FSM, operand logic and ALU consume these outputs.

---
 rtl/calc_pkg.sv | 45 ++++
 rtl/keypad_scanner_if.sv | 28 ++
 rtl/key_decode.sv | 34 +++
 rtl/keypad_scanner.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator front end: scanner FSM states, key classes,
// operation codes and keypad index helpers.
package calc_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int COL_W    = 2;
  localparam int ROW_W    = 2;

  typedef logic [COL_W-1:0] col_idx_t;
  typedef logic [ROW_W-1:0] row_idx_t;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    KEY_NUMBER = 2'd0,
    KEY_OP     = 2'd1,
    KEY_EQUALS = 2'd2,
    KEY_CLEAR  = 2'd3
  } key_class_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Active-low one-hot pattern for a column drive or an expected row pattern.
  function automatic logic [3:0] onehot_low(input logic [1:0] idx);
    onehot_low = ~(4'b0001 << idx);
  endfunction

  // Index of the single low bit; only meaningful when exactly one bit is low.
  function automatic row_idx_t low_index(input logic [3:0] v);
    low_index = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!v[i]) low_index = row_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix pins plus the decoded key outputs consumed by
// the calculator datapath.
interface keypad_scanner_if;

  logic [3:0] rows;
  logic [3:0] cols;
  logic       number_pressed;
  logic       operation_pressed;
  logic       equals_pressed;
  logic       clear_pressed;
  logic       key_pulse;
  logic       key_held;
  logic [3:0] digit;
  logic [1:0] operation;

  modport master (
    input  rows,
    output cols, number_pressed, operation_pressed, equals_pressed,
           clear_pressed, key_pulse, key_held, digit, operation
  );

  modport slave (
    output rows,
    input  cols, number_pressed, operation_pressed, equals_pressed,
           clear_pressed, key_pulse, key_held, digit, operation
  );

endinterface

// File: rtl/key_decode.sv
// Combinational keypad map: (row, col) -> key class, digit and operation code.
module key_decode
  import calc_pkg::*;
(
  input  row_idx_t   i_row,
  input  col_idx_t   i_col,
  output key_class_e o_class,
  output logic [3:0] o_digit,
  output logic [1:0] o_operation
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no path can
    // leave one unassigned, which would otherwise infer a latch.
    o_class     = KEY_NUMBER;
    o_digit     = '0;
    o_operation = OP_ADD;
    if (i_col == col_idx_t'(3)) begin
      // Column 3 holds A..D top to bottom, matching the operation codes.
      o_class     = KEY_OP;
      o_operation = i_row;
    end else if (i_row == row_idx_t'(3)) begin
      unique case (i_col)
        col_idx_t'(0): o_class = KEY_CLEAR;
        col_idx_t'(1): o_digit = 4'd0;
        col_idx_t'(2): o_class = KEY_EQUALS;
        default:       o_class = KEY_NUMBER;
      endcase
    end else begin
      o_digit = {2'b00, i_row} * 4'd3 + {2'b00, i_col} + 4'd1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, 2-flop row sync, press/release
// debounce and key decode with a single-cycle accept strobe.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_TICKS     = 2000,
  parameter int DEBOUNCE_TICKS = 480000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int SLOT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int DB_W   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_TICKS - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);

  scan_state_e       r_state;
  logic [3:0]        r_rows_meta;
  logic [3:0]        r_rows_sync;
  logic [SLOT_W-1:0] r_slot;
  logic [DB_W-1:0]   r_db;
  col_idx_t          r_col_idx;
  row_idx_t          r_row_idx;
  logic [3:0]        r_cols;
  logic              r_number_pressed;
  logic              r_operation_pressed;
  logic              r_equals_pressed;
  logic              r_clear_pressed;
  logic              r_key_pulse;
  logic              r_key_held;
  logic [3:0]        r_digit;
  logic [1:0]        r_operation;

  key_class_e        w_dec_class;
  logic [3:0]        w_dec_digit;
  logic [1:0]        w_dec_op;
  col_idx_t          w_next_col;
  logic              w_rows_idle;
  logic              w_single_low;
  logic              w_rows_is_key;

  key_decode u_key_decode (
    .i_row       (r_row_idx),
    .i_col       (r_col_idx),
    .o_class     (w_dec_class),
    .o_digit     (w_dec_digit),
    .o_operation (w_dec_op)
  );

  assign w_next_col    = r_col_idx + col_idx_t'(1);
  assign w_rows_idle   = &r_rows_sync;
  assign w_single_low  = $onehot(~r_rows_sync);
  assign w_rows_is_key = (r_rows_sync == onehot_low(r_row_idx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state             <= ST_SCAN;
      r_rows_meta         <= 4'hF;
      r_rows_sync         <= 4'hF;
      r_slot              <= '0;
      r_db                <= '0;
      r_col_idx           <= '0;
      r_row_idx           <= '0;
      r_cols              <= 4'b1110;
      r_number_pressed    <= 1'b0;
      r_operation_pressed <= 1'b0;
      r_equals_pressed    <= 1'b0;
      r_clear_pressed     <= 1'b0;
      r_key_pulse         <= 1'b0;
      r_key_held          <= 1'b0;
      r_digit             <= '0;
      r_operation         <= OP_ADD;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision in this
      // cycle sees last cycle's register values regardless of statement order.
      r_rows_meta <= kp.rows;
      r_rows_sync <= r_rows_meta;
      r_key_pulse <= 1'b0;

      unique case (r_state)
        ST_SCAN: begin
          if (r_slot == SLOT_LAST) begin
            r_slot <= '0;
            if (w_single_low) begin
              r_row_idx <= low_index(r_rows_sync);
              r_db      <= '0;
              r_state   <= ST_PRESS_DB;
            end else begin
              // Idle or ghosting: move on without touching the outputs.
              r_col_idx <= w_next_col;
              r_cols    <= onehot_low(w_next_col);
            end
          end else begin
            r_slot <= r_slot + SLOT_W'(1);
          end
        end

        ST_PRESS_DB: begin
          if (!w_rows_is_key) begin
            r_col_idx <= w_next_col;
            r_cols    <= onehot_low(w_next_col);
            r_slot    <= '0;
            r_state   <= ST_SCAN;
          end else if (r_db == DB_LAST) begin
            r_key_pulse         <= 1'b1;
            r_key_held          <= 1'b1;
            r_number_pressed    <= (w_dec_class == KEY_NUMBER);
            r_operation_pressed <= (w_dec_class == KEY_OP);
            r_equals_pressed    <= (w_dec_class == KEY_EQUALS);
            r_clear_pressed     <= (w_dec_class == KEY_CLEAR);
            if (w_dec_class == KEY_NUMBER) r_digit     <= w_dec_digit;
            if (w_dec_class == KEY_OP)     r_operation <= w_dec_op;
            r_state <= ST_HELD;
          end else begin
            r_db <= r_db + DB_W'(1);
          end
        end

        ST_HELD: begin
          if (w_rows_idle) begin
            r_db    <= '0;
            r_state <= ST_RELEASE_DB;
          end
        end

        ST_RELEASE_DB: begin
          if (!w_rows_idle) begin
            r_db <= '0;
          end else if (r_db == DB_LAST) begin
            r_key_held <= 1'b0;
            r_col_idx  <= w_next_col;
            r_cols     <= onehot_low(w_next_col);
            r_slot     <= '0;
            r_state    <= ST_SCAN;
          end else begin
            r_db <= r_db + DB_W'(1);
          end
        end

        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign kp.cols              = r_cols;
  assign kp.number_pressed    = r_number_pressed;
  assign kp.operation_pressed = r_operation_pressed;
  assign kp.equals_pressed    = r_equals_pressed;
  assign kp.clear_pressed     = r_clear_pressed;
  assign kp.key_pulse         = r_key_pulse;
  assign kp.key_held          = r_key_held;
  assign kp.digit             = r_digit;
  assign kp.operation         = r_operation;

endmodule
